// File: rtl/uart_rx_pkg.sv
// Shared definitions for the second-generation UART receiver:
// FSM state encoding, sample-point offsets around the bit centre and data-length bounds.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  // Offsets relative to Prescale/2: three vote samples, then the decision cycle
  localparam int SMP_FIRST_OFS  = -1;
  localparam int SMP_MID_OFS    = 0;
  localparam int SMP_LAST_OFS   = 1;
  localparam int BIT_DECIDE_OFS = 2;

  localparam int MIN_DATA_WIDTH = 5;
  localparam int MAX_DATA_WIDTH = 9;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_w);
    if (int'(len) < MIN_DATA_WIDTH || int'(len) > max_w) return 4'(max_w);
    return len;
  endfunction

endpackage

// File: rtl/uart_rx_gen2_if.sv
// Receive-side output bus: held word with error flags under ready/valid, plus event pulses.
interface uart_rx_gen2_if #(parameter int DATA_WIDTH = 8);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  par_error;
  logic                  stop_error;
  logic                  overrun;
  logic                  break_det;

  modport master (
    output rx_data, rx_valid, par_error, stop_error, overrun, break_det,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, par_error, stop_error, overrun, break_det,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit edge counter and three-sample majority vote.
// bit_valid strobes for one cycle at ec = P/2+2 with the voted bit_value.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  count_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  rxs,
  output logic [PRESCALE_W-1:0] ec,
  output logic                  bit_valid,
  output logic                  bit_value
);

  logic [1:0]            sync;
  logic [2:0]            smp;
  logic [PRESCALE_W-1:0] half;
  int                    rel;

  assign rxs  = sync[1];
  assign half = prescale >> 1;
  assign rel  = int'(ec) - int'(half);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
      ec   <= '0;
      smp  <= 3'b111;
    end else begin
      sync <= {sync[0], rx_in};
      if (!count_en || ec == prescale - PRESCALE_W'(1)) ec <= '0;
      else                                            ec <= ec + PRESCALE_W'(1);
      if (count_en && rel == SMP_FIRST_OFS) smp[0] <= rxs;
      if (count_en && rel == SMP_MID_OFS)   smp[1] <= rxs;
      if (count_en && rel == SMP_LAST_OFS)  smp[2] <= rxs;
    end
  end

  assign bit_valid = count_en && (rel == BIT_DECIDE_OFS);
  assign bit_value = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

endmodule

// File: rtl/uart_rx_gen2.sv
// UART receiver with run-time frame format, majority sampling, break detection and a held
// ready/valid output word; rx_valid rises one cycle after the last stop-bit decision.
module uart_rx_gen2
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [3:0]            data_len,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  two_stop,
  uart_rx_gen2_if.master        rx
);

  localparam int LEN_MAX = (DATA_WIDTH > MAX_DATA_WIDTH) ? MAX_DATA_WIDTH : DATA_WIDTH;

  rx_state_t             state, state_nxt;
  logic                  rxs, rxs_q, bit_valid, bit_value, count_en, start_edge;
  logic [PRESCALE_W-1:0] ec, prescale_q;
  logic [3:0]            len_q, bit_cnt;
  logic                  par_en_q, par_typ_q, two_stop_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err_q, par_bit_q, stop_err_q, stop_idx;
  logic                  load_cfg, complete, brk, stop_err_any, break_cond;

  assign count_en     = state inside {START, DATA, PARITY, STOP};
  assign start_edge   = rxs_q & ~rxs;
  assign stop_err_any = stop_err_q | ~bit_value;
  assign break_cond   = (shreg == '0) && (!par_en_q || !par_bit_q) && !bit_value;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (RX_IN),
    .count_en  (count_en),
    .prescale  (prescale_q),
    .rxs       (rxs),
    .ec        (ec),
    .bit_valid (bit_valid),
    .bit_value (bit_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_cfg  = 1'b0;
    complete  = 1'b0;
    brk       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = START;
          load_cfg  = 1'b1;
        end
      end
      START: begin
        if (bit_valid && bit_value)               state_nxt = IDLE;
        else if (ec == prescale_q - PRESCALE_W'(1)) state_nxt = DATA;
      end
      DATA: begin
        if (bit_valid && bit_cnt == len_q - 4'd1) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_valid) state_nxt = STOP;
      end
      STOP: begin
        if (bit_valid) begin
          // A break is recognised on stop 1 and never waits for a second stop bit
          if (!stop_idx && break_cond) begin
            brk       = 1'b1;
            state_nxt = WAIT_IDLE;
          end else if (!stop_idx && two_stop_q) begin
            state_nxt = STOP;
          end else begin
            complete  = 1'b1;
            state_nxt = stop_err_any ? WAIT_IDLE : IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxs_q      <= 1'b1;
      prescale_q <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      two_stop_q <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_err_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_err_q <= 1'b0;
      stop_idx   <= 1'b0;
    end else begin
      rxs_q <= rxs;
      if (load_cfg) begin
        prescale_q <= Prescale;
        len_q      <= clamp_len(data_len, LEN_MAX);
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        two_stop_q <= two_stop;
        shreg      <= '0;
        bit_cnt    <= '0;
        par_err_q  <= 1'b0;
        par_bit_q  <= 1'b0;
        stop_err_q <= 1'b0;
        stop_idx   <= 1'b0;
      end else if (bit_valid) begin
        unique case (state)
          DATA: begin
            shreg   <= shreg | (DATA_WIDTH'(bit_value) << bit_cnt);
            bit_cnt <= bit_cnt + 4'd1;
          end
          PARITY: begin
            par_bit_q <= bit_value;
            par_err_q <= bit_value != (^shreg ^ par_typ_q);
          end
          STOP: begin
            stop_err_q <= ~bit_value;
            stop_idx   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A completed word overwrites the register only when it is empty or being accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.par_error  <= 1'b0;
      rx.stop_error <= 1'b0;
      rx.overrun    <= 1'b0;
      rx.break_det  <= 1'b0;
    end else begin
      rx.overrun   <= 1'b0;
      rx.break_det <= brk;
      if (complete && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data    <= shreg;
        rx.par_error  <= par_err_q;
        rx.stop_error <= stop_err_any;
        rx.rx_valid   <= 1'b1;
      end else if (complete) begin
        rx.overrun <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Directed bench for uart_rx_gen2: serial frames in, expected words queued, monitor compares.
module tb_uart_rx_gen2;
  import uart_rx_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       se;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic [3:0] data_len = 4'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       two_stop = 1'b0;
  int         prescale_v = 8;

  int   checks = 0;
  int   passes = 0;
  int   overrun_cnt = 0;
  int   break_cnt = 0;
  int   ov0, br0;
  exp_t sb[$];
  exp_t mon_e;

  uart_rx_gen2_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_gen2 #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .RX_IN    (RX_IN),
    .Prescale (Prescale),
    .data_len (data_len),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .two_stop (two_stop),
    .rx       (rx_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg(input int p, input int len, input logic pe, input logic pt, input logic ts);
    prescale_v = p;
    Prescale   = 6'(p);
    data_len   = 4'(len);
    PAR_EN     = pe;
    PAR_TYP    = pt;
    two_stop   = ts;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    for (int c = 0; c < prescale_v; c++) begin
      RX_IN = (glitch && c == prescale_v / 2 + 1) ? ~b : b;
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [8:0] data, input int len, input logic par_bit,
                            input logic stop1, input logic stop2, input int glitch_bit);
    logic [8:0] d;
    d = data;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      send_bit(d[0], i == glitch_bit);
      d = d >> 1;
    end
    if (PAR_EN) send_bit(par_bit, 1'b0);
    send_bit(stop1, 1'b0);
    if (two_stop) send_bit(stop2, 1'b0);
  endtask

  task automatic idle(input int nbits);
    RX_IN = 1'b1;
    tick(nbits * prescale_v);
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic se);
    sb.push_back('{data: d, pe: pe, se: se});
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() > 0; i++) tick(1);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"},    32'(rx_if.rx_data),    32'd0);
    check({tag, "_rx_valid"},   32'(rx_if.rx_valid),   32'd0);
    check({tag, "_par_error"},  32'(rx_if.par_error),  32'd0);
    check({tag, "_stop_error"}, 32'(rx_if.stop_error), 32'd0);
    check({tag, "_overrun"},    32'(rx_if.overrun),    32'd0);
    check({tag, "_break_det"},  32'(rx_if.break_det),  32'd0);
    check({tag, "_state"},      32'(dut.state),        32'(IDLE));
  endtask

  // Monitor: every accepted word must match the head of the scoreboard
  always @(negedge clk) begin
    if (rx_if.overrun)   overrun_cnt++;
    if (rx_if.break_det) break_cnt++;
    if (rst && rx_if.rx_valid && rx_if.rx_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got %0h, required no output", rx_if.rx_data);
      end else begin
        mon_e = sb.pop_front();
        check("rx_data",    32'(rx_if.rx_data),    32'(mon_e.data));
        check("par_error",  32'(rx_if.par_error),  32'(mon_e.pe));
        check("stop_error", 32'(rx_if.stop_error), 32'(mon_e.se));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $finish;
  end

  initial begin
    rx_if.rx_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check_all_zero("reset");
    tick(1);
    rst = 1'b1;
    tick(4);

    // 0xA5, even parity (bit 0), accepted at once
    cfg(8, 8, 1'b1, 1'b0, 1'b0);
    push(8'hA5, 1'b0, 1'b0);
    send_frame(9'h0A5, 8, 1'b0, 1'b1, 1'b1, -1);
    idle(2);
    wait_drain(32);

    // 5-bit odd parity, two stops: wrong parity, then bad second stop
    cfg(16, 5, 1'b1, 1'b1, 1'b1);
    push(8'h13, 1'b1, 1'b0);
    send_frame(9'h013, 5, 1'b1, 1'b1, 1'b1, -1);
    idle(2);
    wait_drain(64);
    push(8'h0A, 1'b0, 1'b1);
    send_frame(9'h00A, 5, 1'b1, 1'b1, 1'b0, -1);
    tick(6);
    @(negedge clk);
    check("wait_idle_state", 32'(dut.state), 32'(WAIT_IDLE));
    tick(1);
    RX_IN = 1'b1;
    tick(5);
    @(negedge clk);
    check("idle_after_wait", 32'(dut.state), 32'(IDLE));
    tick(1);
    wait_drain(16);
    idle(2);

    // Short low pulse is a false start; single-cycle glitch inside a data bit is voted out
    cfg(8, 8, 1'b1, 1'b0, 1'b0);
    RX_IN = 1'b0;
    tick(2);
    RX_IN = 1'b1;
    tick(20);
    @(negedge clk);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    check("glitch_no_valid", 32'(rx_if.rx_valid), 32'd0);
    tick(1);
    push(8'h5A, 1'b0, 1'b0);
    send_frame(9'h05A, 8, 1'b0, 1'b1, 1'b1, 3);
    idle(2);
    wait_drain(32);

    // Overrun: second word dropped while first is held
    cfg(8, 8, 1'b0, 1'b0, 1'b0);
    rx_if.rx_ready = 1'b0;
    ov0 = overrun_cnt;
    push(8'h3C, 1'b0, 1'b0);
    send_frame(9'h03C, 8, 1'b0, 1'b1, 1'b1, -1);
    idle(2);
    send_frame(9'h0C3, 8, 1'b0, 1'b1, 1'b1, -1);
    idle(2);
    @(negedge clk);
    check("overrun_pulses", 32'(overrun_cnt - ov0), 32'd1);
    check("held_valid", 32'(rx_if.rx_valid), 32'd1);
    check("held_data", 32'(rx_if.rx_data), 32'h3C);
    tick(1);
    rx_if.rx_ready = 1'b1;
    wait_drain(8);
    tick(2);
    @(negedge clk);
    check("valid_dropped", 32'(rx_if.rx_valid), 32'd0);
    tick(1);

    // Break: 12 bit times low with parity enabled, then a normal frame
    cfg(8, 8, 1'b1, 1'b0, 1'b0);
    br0 = break_cnt;
    RX_IN = 1'b0;
    tick(96);
    idle(2);
    @(negedge clk);
    check("break_pulses", 32'(break_cnt - br0), 32'd1);
    check("break_no_valid", 32'(rx_if.rx_valid), 32'd0);
    check("break_state", 32'(dut.state), 32'(IDLE));
    tick(1);
    push(8'h55, 1'b0, 1'b0);
    send_frame(9'h055, 8, 1'b0, 1'b1, 1'b1, -1);
    idle(2);
    wait_drain(32);

    // Reset during DATA of 0xFF; only the following 0x01 may appear
    cfg(8, 8, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    tick(2);
    rst = 1'b1;
    idle(1);
    push(8'h01, 1'b0, 1'b0);
    send_frame(9'h001, 8, 1'b0, 1'b1, 1'b1, -1);
    idle(2);
    wait_drain(32);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
